// File: rtl/clock_core_pkg.sv
// Shared select codes, field limits and the 12 h display helper for clock_core.
package clock_core_pkg;

   typedef enum logic [1:0] {
      SELECT_SEC  = 2'd0,
      SELECT_MIN  = 2'd1,
      SELECT_HOUR = 2'd2,
      SELECT_NONE = 2'd3
   } select_e;

   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;
   localparam int HOUR_MAX = 23;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
      logic [HOUR_W-1:0] result;
      result = hour;
      if (hour == '0) begin
         result = HOUR_W'(12);
      end else if (hour > HOUR_W'(12)) begin
         result = hour - HOUR_W'(12);
      end
      return result;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter; clr beats inc, carry flags the wrapping increment.
module mod_counter #(
   parameter int WIDTH = 6,
   parameter int MAX   = 59
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] value,
   output logic             carry
);

   logic [WIDTH-1:0] value_q, value_d;
   logic             at_max;

   assign at_max = (value_q == WIDTH'(MAX));

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end else if (inc) begin
         value_d = at_max ? '0 : value_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign carry = inc && at_max;

endmodule

// File: rtl/clock_core.sv
// Time-of-day counter: prescaled seconds tick, sec/min/hour fields, synchronised front-panel edits.
// Optional alarm compare is built when CLOCK_ALARM_EN is defined.
module clock_core
   import clock_core_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int PRESC_W       = $clog2(TICKS_PER_SEC),
   parameter int SYNC_STAGES   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic [1:0]        select,
   input  logic              increment,
   input  logic              hour_mode,
`ifdef CLOCK_ALARM_EN
   input  logic              alarm_set,
`endif
   output logic [SEC_W-1:0]  sec_out,
   output logic [MIN_W-1:0]  min_out,
   output logic [HOUR_W-1:0] hour_out,
   output logic              pm_out,
   output logic              sec_tick,
   output logic              alarm_pulse
);

   logic [PRESC_W-1:0]     presc_q, presc_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;
   logic                   sec_tick_q, sec_tick_d;

   logic edit, tick, tick_adv, alarm_sel;
   logic edit_sec, edit_min, edit_hour;
   logic sec_carry, min_carry, hour_carry_unused;
   logic [SEC_W-1:0]  sec_q;
   logic [MIN_W-1:0]  min_q;
   logic [HOUR_W-1:0] hour_q;

   assign edit      = sync_q[SYNC_STAGES-1] & ~edge_q;
   assign tick      = run && (presc_q == PRESC_W'(TICKS_PER_SEC - 1));
   // An edit swallows a coincident tick; the prescaler still wraps.
   assign tick_adv  = tick && !edit;
   assign edit_sec  = edit && (select == SELECT_SEC);
   assign edit_min  = edit && (select == SELECT_MIN)  && !alarm_sel;
   assign edit_hour = edit && (select == SELECT_HOUR) && !alarm_sel;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], increment};
      edge_d     = sync_q[SYNC_STAGES-1];
      sec_tick_d = tick_adv;
      presc_d    = presc_q;
      if (edit_sec || tick) begin
         presc_d = '0;
      end else if (run) begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q    <= '0;
         sync_q     <= '0;
         edge_q     <= 1'b0;
         sec_tick_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         sync_q     <= sync_d;
         edge_q     <= edge_d;
         sec_tick_q <= sec_tick_d;
      end
   end

   mod_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (tick_adv),
      .clr     (edit_sec),
      .value   (sec_q),
      .carry   (sec_carry)
   );

   mod_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (sec_carry || edit_min),
      .clr     (1'b0),
      .value   (min_q),
      .carry   (min_carry)
   );

   // Minute edits wrap without carrying into the hour.
   mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     ((min_carry && tick_adv) || edit_hour),
      .clr     (1'b0),
      .value   (hour_q),
      .carry   (hour_carry_unused)
   );

`ifdef CLOCK_ALARM_EN
   logic [MIN_W-1:0]  alarm_min_q, alarm_min_d, min_nxt;
   logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d, hour_nxt;
   logic              alarm_pulse_q, alarm_pulse_d;

   assign alarm_sel = alarm_set;

   always_comb begin
      alarm_min_d  = alarm_min_q;
      alarm_hour_d = alarm_hour_q;
      if (edit && alarm_set && (select == SELECT_MIN)) begin
         alarm_min_d = (alarm_min_q == MIN_W'(MIN_MAX)) ? '0 : alarm_min_q + MIN_W'(1);
      end
      if (edit && alarm_set && (select == SELECT_HOUR)) begin
         alarm_hour_d = (alarm_hour_q == HOUR_W'(HOUR_MAX)) ? '0 : alarm_hour_q + HOUR_W'(1);
      end
      min_nxt  = min_carry ? '0 : min_q + MIN_W'(1);
      hour_nxt = hour_q;
      if (min_carry) begin
         hour_nxt = (hour_q == HOUR_W'(HOUR_MAX)) ? '0 : hour_q + HOUR_W'(1);
      end
      // sec_carry only asserts on an accepted tick out of second 59.
      alarm_pulse_d = sec_carry && (min_nxt == alarm_min_q) && (hour_nxt == alarm_hour_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_min_q   <= '0;
         alarm_hour_q  <= '0;
         alarm_pulse_q <= 1'b0;
      end else begin
         alarm_min_q   <= alarm_min_d;
         alarm_hour_q  <= alarm_hour_d;
         alarm_pulse_q <= alarm_pulse_d;
      end
   end

   assign alarm_pulse = alarm_pulse_q;
`else
   assign alarm_sel   = 1'b0;
   assign alarm_pulse = 1'b0;
`endif

   assign sec_out  = sec_q;
   assign min_out  = min_q;
   assign hour_out = hour_mode ? to_12h(hour_q) : hour_q;
   assign pm_out   = (hour_q >= HOUR_W'(12));
   assign sec_tick = sec_tick_q;

endmodule

// File: doc/clock_core.md
# clock_core

Parametrised time-of-day counter for the digital clock. Derives one-second ticks from the system clock with an internal prescaler, keeps seconds/minutes/hours, and accepts field edits from the front-panel select/increment controls. Edits are synchronised and applied in the `clk` domain. Sits between the board clock/buttons and the display formatter, which consumes its BCD-free binary time outputs.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per second; must be ≥2.
- `PRESC_W`, default `$clog2(TICKS_PER_SEC)`: prescaler width.
- `SYNC_STAGES`, default 2: synchroniser depth on `increment`; must be ≥2.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `run` in 1: 1 = time advances; 0 = prescaler frozen, time held.
- `select` in 2: field to edit; 0 = sec, 1 = min, 2 = hour, 3 = none.
- `increment` in 1: asynchronous button level; each rising edge = one edit.
- `hour_mode` in 1: 0 = 24 h display, 1 = 12 h display.
- `sec_out` out 6: seconds 0–59.
- `min_out` out 6: minutes 0–59.
- `hour_out` out 5: 0–23 (24 h) or 1–12 (12 h).
- `pm_out` out 1: 1 when internal hour ≥12, in both modes.
- `sec_tick` out 1: one-cycle pulse per second advance.
- `alarm_pulse` out 1: one-cycle pulse on alarm match (tied 0 without `CLOCK_ALARM_EN`).

## Operation
- Reset (`reset_n`=0): prescaler, sec, min, internal hour, synchroniser and edge flops = 0. Outputs: `sec_out`/`min_out`=0, `pm_out`=0, `sec_tick`=0, `alarm_pulse`=0. `hour_out`=0 in 24 h mode, 12 in 12 h mode.
- Prescaler: counts 0..`TICKS_PER_SEC`-1 while `run`=1. At terminal count it wraps to 0 and generates a tick. `run`=0 freezes it mid-count; it resumes from the same value.
- Tick: sec+1. At 59 it wraps to 0 with carry to min. Min at 59 wraps to 0 with carry to hour. Hour at 23 wraps to 0. 23:59:59 → 00:00:00 in one edge.
- Edit pulse: rising edge of the synchronised `increment`, one cycle wide.
  - sec: sec and prescaler cleared to 0.
  - min: min+1 mod 60, no carry to hour.
  - hour: internal hour+1 mod 24.
  - none: no effect.
- Edits apply regardless of `run`.
- Edit and tick in the same cycle: the edit wins; that tick is discarded entirely (no field advances). The prescaler still wraps normally. At most one second is lost per edit.
- 12 h conversion is combinational on the registered internal hour: 0 → 12, 1–12 → same, 13–23 → h-12. `hour_mode` may change any cycle with no state effect.
- `select` is sampled only in the edit-pulse cycle. It is quasi-static and is not synchronised.

## Timing
- Tick at edge N (prescaler at terminal): time registers update at edge N. `sec_tick` is high for the cycle after edge N.
- `increment` rising before edge k: edit applied at edge k+`SYNC_STAGES`. Held high produces no repeat. Glitches shorter than one `clk` period may be lost.
- Reset deassertion mid-count: counting restarts from 0. First tick arrives `TICKS_PER_SEC` cycles after the first edge with `run`=1.
- Outputs are registered except `hour_out`/`pm_out`, which are combinational from registered state.

## Configuration
- `CLOCK_ALARM_EN` defined:
  - Adds alarm hour/minute registers (reset 00:00) and an `alarm_set` input (1 bit). While it is 1, edit pulses with `select` = min/hour edit the alarm instead of time.
  - `alarm_pulse` fires for one cycle on the tick that makes time equal alarm:00.
- Not defined: no alarm registers or `alarm_set` port; `alarm_pulse` is constant 0.

## Structure
- Shared package/constants: select codes `SELECT_SEC`=0, `SELECT_MIN`=1, `SELECT_HOUR`=2, `SELECT_NONE`=3; limits `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23.
- Sub-module `mod_counter`:
  - Parameters: `WIDTH`, `MAX`.
  - Inputs: `inc`, `clr`.
  - Outputs: `value`, `carry` (combinational, =`inc` && value==`MAX`).
  - Instanced for sec, min and hour.
- Edge synchroniser stays inline.

## Test plan
With `TICKS_PER_SEC`=4:
- Reset, `run`=1 for 16 cycles → `sec_out`=4, four `sec_tick` pulses spaced 4 cycles apart.
- Force 23:59:59 via edits, then one tick → 00:00:00 on the same edge, `pm_out` 1→0.
- `select`=min at min 59, one `increment` edge → min 0, hour unchanged. Edit visible exactly `SYNC_STAGES` edges after the rising edge.
- Edit pulse aligned with the tick cycle at sec 10 → sec stays 10; the next tick gives 11.
- `hour_mode`=1 over internal hours 0, 12, 13 → `hour_out` 12/12/1, `pm_out` 0/1/1.
- `run`=0 for 20 cycles → no tick and time unchanged. `reset_n` pulsed mid-count → all outputs at reset values immediately, without waiting for a clock edge.
